// File: rtl/s5851a_temp_fmt.sv
// Polls the S-5851A sequencer for a temperature reading and formats it as a
// 6-character ASCII field ("+125.9" style) for the character overlay.
module s5851a_temp_fmt #(
    parameter int C_F_CK    = 135_000_000,
    parameter int C_POLL_HZ = 4,
    parameter int C_TMO_CYC = 1_000_000
) (
    input  logic        CK_i,
    input  logic        XARST_i,
    input  logic        EN_i,
    input  logic [11:0] TEMPs_i,
    input  logic        DONE_i,
    output logic        REQ_o,
    output logic [47:0] CHARs_o,
    output logic        VALID_o,
    output logic        ERR_o,
    output logic        BUSY_o
);

    // Handshake: REQ_o is a single-cycle strobe; the sequencer answers with a
    // single-cycle DONE_i carrying TEMPs_i. VALID_o strobes once per CHARs_o update.

    localparam int C_POLL_CYC = C_F_CK / C_POLL_HZ;
    localparam int PW         = $clog2(C_POLL_CYC + 1);
    localparam int TW         = $clog2(C_TMO_CYC + 1);

    localparam logic [PW-1:0] POLL_RELOAD = PW'(C_POLL_CYC - 1);
    localparam logic [TW-1:0] TMO_LAST    = TW'(C_TMO_CYC - 1);
    localparam logic [47:0]   CHARS_BLANK = 48'h20_20_20_20_20_20;
    localparam logic [47:0]   CHARS_ERR   = 48'h2D_2D_2D_2D_2E_2D;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_CONV = 2'd2,
        ST_OUT  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] poll_q, poll_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [2:0]    iter_q, iter_d;
    logic [19:0]   sr_q, sr_d;
    logic          sign_q, sign_d;
    logic [3:0]    tenths_q, tenths_d;
    logic          req_q, req_d;
    logic          valid_q, valid_d;
    logic          err_q, err_d;
    logic [47:0]   chars_q, chars_d;

    logic [11:0]   mag;
    logic [3:0]    tenths_in;
    logic [19:0]   sr_step;
    logic [3:0]    hund, tens, ones;
    logic [47:0]   chars_fmt;

    // 0x800 negates to itself, which read as unsigned is the wanted 2048.
    always_comb begin
        mag       = TEMPs_i[11] ? (12'd0 - TEMPs_i) : TEMPs_i;
        tenths_in = 4'((({4'd0, mag[3:0]} * 8'd10) >> 4));
    end

    // One double-dabble iteration: BCD digits live in sr[19:8], binary in sr[7:0].
    always_comb begin
        sr_step = sr_q;
        for (int i = 0; i < 3; i++) begin
            if (sr_step[8 + 4*i +: 4] >= 4'd5)
                sr_step[8 + 4*i +: 4] = sr_step[8 + 4*i +: 4] + 4'd3;
        end
        sr_step = {sr_step[18:0], 1'b0};
    end

    always_comb begin
        hund      = sr_q[19:16];
        tens      = sr_q[15:12];
        ones      = sr_q[11:8];
        chars_fmt = {sign_q ? 8'h2D : 8'h2B,
                     (hund == 4'd0) ? 8'h20 : {4'h3, hund},
                     ((hund == 4'd0) && (tens == 4'd0)) ? 8'h20 : {4'h3, tens},
                     {4'h3, ones},
                     8'h2E,
                     {4'h3, tenths_q}};
    end

    always_comb begin
        state_d  = state_q;
        tmo_d    = tmo_q;
        iter_d   = iter_q;
        sr_d     = sr_q;
        sign_d   = sign_q;
        tenths_d = tenths_q;
        err_d    = err_q;
        chars_d  = chars_q;
        req_d    = 1'b0;
        valid_d  = 1'b0;
        poll_d   = (poll_q == '0) ? POLL_RELOAD : poll_q - PW'(1);

        case (state_q)
            ST_IDLE: begin
                if ((poll_q == '0) && EN_i) begin
                    req_d   = 1'b1;
                    tmo_d   = '0;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                tmo_d = tmo_q + TW'(1);
                if (DONE_i) begin
                    sign_d   = TEMPs_i[11];
                    tenths_d = tenths_in;
                    sr_d     = {12'd0, mag[11:4]};
                    iter_d   = '0;
                    state_d  = ST_CONV;
                end else if (tmo_q == TMO_LAST) begin
                    chars_d = CHARS_ERR;
                    err_d   = 1'b1;
                    valid_d = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_CONV: begin
                sr_d   = sr_step;
                iter_d = iter_q + 3'd1;
                if (iter_q == 3'd7)
                    state_d = ST_OUT;
            end
            ST_OUT: begin
                chars_d = chars_fmt;
                valid_d = 1'b1;
                err_d   = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CK_i or negedge XARST_i) begin
        if (!XARST_i) begin
            state_q  <= ST_IDLE;
            poll_q   <= POLL_RELOAD;
            tmo_q    <= '0;
            iter_q   <= '0;
            sr_q     <= '0;
            sign_q   <= 1'b0;
            tenths_q <= '0;
            req_q    <= 1'b0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
            chars_q  <= CHARS_BLANK;
        end else begin
            state_q  <= state_d;
            poll_q   <= poll_d;
            tmo_q    <= tmo_d;
            iter_q   <= iter_d;
            sr_q     <= sr_d;
            sign_q   <= sign_d;
            tenths_q <= tenths_d;
            req_q    <= req_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
            chars_q  <= chars_d;
        end
    end

    assign REQ_o   = req_q;
    assign VALID_o = valid_q;
    assign ERR_o   = err_q;
    assign CHARs_o = chars_q;
    assign BUSY_o  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_s5851a_temp_fmt.sv
// Randomized bench for s5851a_temp_fmt against an arithmetic model of the
// ASCII temperature field, plus directed timeout, enable and reset cases.
module tb_s5851a_temp_fmt;

  localparam int F_CK    = 300;
  localparam int POLL_HZ = 1;
  localparam int TMO     = 40;
  localparam int P       = F_CK / POLL_HZ;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b1;
  logic        done = 1'b0;
  logic [11:0] temps = '0;
  logic        req_o, valid_o, err_o, busy_o;
  logic [47:0] chars_o;

  s5851a_temp_fmt #(.C_F_CK(F_CK), .C_POLL_HZ(POLL_HZ), .C_TMO_CYC(TMO)) dut (
    .CK_i(clk), .XARST_i(rst_n), .EN_i(en), .TEMPs_i(temps), .DONE_i(done),
    .REQ_o(req_o), .CHARs_o(chars_o), .VALID_o(valid_o), .ERR_o(err_o), .BUSY_o(busy_o)
  );

  // clock / cycle bookkeeping
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc++;
  int req_cnt = 0;
  int valid_cnt = 0;
  always @(negedge clk) begin
    if (req_o) req_cnt++;
    if (valid_o) valid_cnt++;
  end

  int n_checks = 0;
  int n_pass = 0;
  int rel_cyc = 0;
  int req_cyc = 0;
  logic [47:0] exp_q[$];

  task automatic check(input string tag, input logic [47:0] got, input logic [47:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // reference: two's-complement sixteenths -> "sDDD.T" with leading blanks
  function automatic logic [47:0] model(input logic [11:0] t);
    int v, m, ip, tn, h, te, o;
    logic [7:0] s, hc, tc;
    v  = {{20{t[11]}}, t};
    m  = (v < 0) ? -v : v;
    ip = m / 16;
    tn = ((m % 16) * 10) / 16;
    h  = ip / 100;
    te = (ip / 10) % 10;
    o  = ip % 10;
    s  = (v < 0) ? 8'h2D : 8'h2B;
    hc = (h == 0) ? 8'h20 : 8'(8'h30 + h);
    tc = (h == 0 && te == 0) ? 8'h20 : 8'(8'h30 + te);
    return {s, hc, tc, 8'(8'h30 + o), 8'h2E, 8'(8'h30 + tn)};
  endfunction

  task automatic release_reset();
    @(negedge clk);
    rst_n   = 1'b1;
    rel_cyc = cyc;
  endtask

  task automatic measure_first_req(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!req_o && n < P + 10);
    req_cyc = cyc;
    check({tag, "_first_req_lat"}, 48'(n), 48'(P));
  endtask

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 2 * P + 10; i++) begin
      @(negedge clk);
      if (req_o) begin
        ok = 1'b1;
        req_cyc = cyc;
        break;
      end
    end
    check("req_seen", 48'(ok), 48'd1);
    if (ok) begin
      check("req_phase", 48'((req_cyc - rel_cyc) % P), 48'd0);
      check("busy_wait", 48'(busy_o), 48'd1);
    end
  endtask

  // serve one request: DONE after `delay` WAIT cycles, optional EN drop and stray DONE in CONV
  task automatic do_read(input logic [11:0] t, input int delay, input bit have_req,
                         input bit drop_en, input bit noise);
    bit ok;
    int lat;
    ok = 1'b1;
    if (!have_req) wait_req(ok);
    if (!ok) return;
    if (drop_en) en = 1'b0;
    repeat (delay) @(negedge clk);
    temps = t;
    done  = 1'b1;
    exp_q.push_back(model(t));
    @(negedge clk);
    done  = 1'b0;
    temps = 12'($urandom);
    check("busy_conv", 48'(busy_o), 48'd1);
    lat = 0;
    while (!valid_o && lat < 40) begin
      done = (noise && lat == 3);
      @(negedge clk);
      lat++;
    end
    done = 1'b0;
    check("valid_lat", 48'(lat), 48'd9);
    if (exp_q.size() > 0) check("chars", chars_o, exp_q.pop_front());
    check("err_clear", 48'(err_o), 48'd0);
    check("busy_idle", 48'(busy_o), 48'd0);
    @(negedge clk);
    check("valid_width", 48'(valid_o), 48'd0);
    en = 1'b1;
  endtask

  task automatic do_timeout(input bit have_req);
    bit ok;
    int c;
    ok = 1'b1;
    if (!have_req) wait_req(ok);
    if (!ok) return;
    c = 0;
    while (!valid_o && c < TMO + 20) begin
      @(negedge clk);
      c++;
    end
    check("tmo_lat", 48'(c), 48'(TMO));
    check("tmo_chars", chars_o, 48'h2D2D2D2D2E2D);
    check("tmo_err", 48'(err_o), 48'd1);
    @(negedge clk);
    check("tmo_valid_width", 48'(valid_o), 48'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req"}, 48'(req_o), 48'd0);
    check({tag, "_valid"}, 48'(valid_o), 48'd0);
    check({tag, "_err"}, 48'(err_o), 48'd0);
    check({tag, "_busy"}, 48'(busy_o), 48'd0);
    check({tag, "_chars"}, chars_o, 48'h202020202020);
  endtask

  initial begin
    int s_req, s_val, c, k, exp_e;
    logic [11:0] dir_t[6];
    bit ok;
    dir_t = '{12'h198, 12'h7DF, 12'h800, 12'hC90, 12'hFFF, 12'h000};

    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    release_reset();
    measure_first_req("por");
    check("req_width_pre", 48'(req_o), 48'd1);

    // first request is left unanswered
    do_timeout(1'b1);
    @(negedge clk);
    check("err_held", 48'(err_o), 48'd1);

    // DONE exactly on the last WAIT cycle still converts
    do_read(12'h198, TMO - 1, 1'b0, 1'b0, 1'b0);
    foreach (dir_t[i]) do_read(dir_t[i], i, 1'b0, 1'b0, 1'b0);

    // polling disabled for three periods; stray DONE pulses while idle
    en    = 1'b0;
    s_req = req_cnt;
    s_val = valid_cnt;
    for (int i = 0; i < 3 * P; i++) begin
      @(negedge clk);
      done  = ($urandom_range(0, 29) == 0);
      temps = 12'($urandom);
    end
    @(negedge clk);
    done = 1'b0;
    @(negedge clk);
    check("en_off_req", 48'(req_cnt - s_req), 48'd0);
    check("en_off_valid", 48'(valid_cnt - s_val), 48'd0);
    c = cyc;
    en = 1'b1;
    k = (c + 1 - rel_cyc + P - 1) / P;
    exp_e = rel_cyc + k * P;
    wait_req(ok);
    check("en_on_req_cyc", 48'(req_cyc), 48'(exp_e));
    if (ok) do_read(12'hC90, 2, 1'b1, 1'b0, 1'b0);

    for (int i = 0; i < 20; i++) begin
      do_read(12'($urandom), $urandom_range(0, TMO - 1), 1'b0,
              $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0);
    end

    // reset in the middle of a conversion
    wait_req(ok);
    if (ok) begin
      temps = 12'h7DF;
      done  = 1'b1;
      @(negedge clk);
      done = 1'b0;
      repeat (3) @(negedge clk);
      check("busy_before_rst", 48'(busy_o), 48'd1);
      rst_n = 1'b0;
      #1;
      check_reset_outputs("conv_rst");
      exp_q.delete();
      repeat (4) @(negedge clk);
      check_reset_outputs("conv_rst_hold");
      release_reset();
      measure_first_req("post_rst");
      do_read(12'h7DF, 5, 1'b1, 1'b0, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
